imem_load_arb: RTL
==================

Name: imem_load_arb

Overview:
- Arbiter and sequencer for the instruction memory: three 9-bit lanes, 1024 words, one read port shared with a write port.
- Normally passes the fetch address from the program-counter block straight through to memory.
- When the external loader (UART/debug bridge) requests access, it:
  - stalls the core,
  - packs loader bytes into 27-bit instruction words,
  - writes them to sequential addresses,
  - then hands memory back to fetch cleanly.

Parameters:
- AWIDTH, 10, instruction-word address width (memory depth 2^AWIDTH).
- LANE_W, 9, width of one memory lane.
- LANES, 3, number of lanes; word width W = LANE_W*LANES = 27.
- BPW, 4, loader bytes per word; must satisfy 8*BPW >= W.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- fetch_addr  in  AWIDTH  word address requested by PC block.
- fetch_stall  out  1  high: PC block must hold PC and ignore instruction data.
- mem_addr  out  AWIDTH  address to all lanes.
- mem_wdata  out  W  write data; lane k = bits [LANE_W*(k+1)-1 : LANE_W*k].
- mem_we  out  LANES  per-lane write enable.
- mem_rdata  in  W  read data (used only with optional feature); 1-cycle read latency.
- ld_req  in  1  loader requests ownership; level, held for whole session.
- ld_base  in  AWIDTH  start address; sampled when the session is granted.
- ld_byte  in  8  loader data byte.
- ld_valid  in  1  ld_byte valid.
- ld_ready  out  1  arbiter accepts ld_byte this cycle.
- ld_grant  out  1  session active (core halted).
- ld_wrap  out  1  sticky: write address wrapped past 2^AWIDTH-1.
- ld_err  out  1  sticky: session ended with a partial word (or mismatch, see optional feature).

Behaviour:
- Reset (rst=0, async): state RUN; fetch_stall=0, mem_we=0, ld_ready=0, ld_grant=0, ld_wrap=0, ld_err=0, byte count=0, word counter=0. mem_addr=fetch_addr.
- States: RUN, DRAIN, COLLECT, WRITE, RESUME.
- RUN
  - mem_addr=fetch_addr, mem_we=0, fetch_stall=0.
  - ld_req=1 -> DRAIN; at this edge: word counter <= ld_base, byte count <= 0, ld_wrap <= 0, ld_err <= 0.
- DRAIN (1 cycle)
  - fetch_stall=1 so the in-flight ROM read is discarded; -> COLLECT.
  - ld_grant rises on entry to DRAIN and stays high until RUN is re-entered.
- COLLECT
  - fetch_stall=1, ld_ready=1.
  - Byte transfer when ld_valid & ld_ready; bytes packed little-endian: byte i -> shift-register bits [8i+7:8i].
  - On transfer of byte BPW-1 -> WRITE.
  - If ld_req=0 -> RESUME. If byte count != 0 at that point, the partial word is dropped and ld_err <= 1.
  - ld_req=0 has priority over a simultaneous final byte: the word is not written and ld_err is set.
- WRITE (1 cycle)
  - ld_ready=0, mem_addr=word counter, mem_we=all ones, mem_wdata=packed[W-1:0].
  - Packed bits [8*BPW-1:W] are ignored.
  - Word counter increments modulo 2^AWIDTH; increment from 2^AWIDTH-1 sets ld_wrap.
  - Byte count <= 0; -> COLLECT.
- RESUME (1 cycle)
  - fetch_stall=1, mem_addr=fetch_addr (re-prime ROM read) -> RUN.
  - fetch_stall is deasserted one cycle after the re-primed read, so the first instruction seen by the core is valid.
- ld_req reasserted during RESUME is ignored until RUN.
- ld_ready is a registered output. Write throughput is one word per BPW+1 cycles.
- mem_we is never high outside WRITE. mem_addr is registered-free (combinational mux on state).
- Reset mid-session: immediate return to RUN, pending word lost, no write issued.

Optional Feature:
- Macro IMEM_LOAD_VERIFY_EN.
- When defined:
  - After each WRITE, add state VERIFY (2 cycles): drive mem_addr=written address, compare mem_rdata with the written word on the second cycle.
  - A mismatch sets ld_err.
  - ld_ready stays low during VERIFY; throughput becomes one word per BPW+3 cycles.
- When undefined: no VERIFY state, mem_rdata unused, and ld_err reports only partial words.

Test Plan:
- Reset, fetch_addr sweeps 0..5 -> mem_addr follows fetch_addr same cycle; fetch_stall=0, mem_we=0, ld_grant=0.
- ld_req=1, ld_base=0x010, bytes 0x78,0x56,0x34,0x12 back-to-back -> one WRITE at addr 0x010, mem_wdata=0x2345678 (27 LSBs), mem_we=3'b111; counter becomes 0x011.
- Two words at ld_base=0x3FF -> writes at 0x3FF then 0x000; ld_wrap=1 after the first write.
- Two bytes sent, then ld_req=0 -> no write; ld_err=1; RESUME one cycle, then RUN with fetch_stall=0 on the following cycle.
- ld_valid toggling every other cycle during a word -> bytes accepted only when ld_valid=1; word written correctly; fetch_stall held continuously.
- With IMEM_LOAD_VERIFY_EN, memory model corrupts lane 1 on write -> ld_err=1 after VERIFY; without the macro, same stimulus -> ld_err=0.

Source files
------------

// File: rtl/imem_load_arb.sv
// rtl/imem_load_arb.sv - instruction memory arbiter between core fetch and byte loader
// Optional read-back check of each written word when IMEM_LOAD_VERIFY_EN is defined.
module imem_load_arb #(
  parameter int AWIDTH = 10,
  parameter int LANE_W = 9,
  parameter int LANES  = 3,
  parameter int BPW    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [AWIDTH-1:0]       fetch_addr,
  output logic                    fetch_stall,
  output logic [AWIDTH-1:0]       mem_addr,
  output logic [LANE_W*LANES-1:0] mem_wdata,
  output logic [LANES-1:0]        mem_we,
  input  logic [LANE_W*LANES-1:0] mem_rdata,
  input  logic                    ld_req,
  input  logic [AWIDTH-1:0]       ld_base,
  input  logic [7:0]              ld_byte,
  input  logic                    ld_valid,
  output logic                    ld_ready,
  output logic                    ld_grant,
  output logic                    ld_wrap,
  output logic                    ld_err
);

  localparam int W  = LANE_W * LANES;
  localparam int SW = 8 * BPW;
  localparam int CW = $clog2(BPW + 1);

  typedef enum logic [2:0] {
    S_RUN,
    S_DRAIN,
    S_COLLECT,
    S_WRITE,
`ifdef IMEM_LOAD_VERIFY_EN
    S_VERIFY1,
    S_VERIFY2,
`endif
    S_RESUME
  } state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     byte_cnt;
  logic [AWIDTH-1:0] word_cnt;
  logic [SW-1:0]     pack_q;
  logic              xfer;

  assign xfer        = ld_valid & ld_ready;
  assign ld_grant    = (state != S_RUN);
  assign fetch_stall = ld_grant;
  assign mem_wdata   = pack_q[W-1:0];

`ifndef IMEM_LOAD_VERIFY_EN
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;
`endif

  always_comb begin
    state_nx = state;
    mem_addr = fetch_addr;
    mem_we   = '0;
    case (state)
      S_RUN:     if (ld_req) state_nx = S_DRAIN;
      S_DRAIN:   state_nx = S_COLLECT;
      // Dropping ld_req wins over a completing byte: the word is abandoned.
      S_COLLECT: begin
        if (!ld_req)
          state_nx = S_RESUME;
        else if (xfer && byte_cnt == CW'(BPW - 1))
          state_nx = S_WRITE;
      end
      S_WRITE: begin
        mem_addr = word_cnt;
        mem_we   = '1;
`ifdef IMEM_LOAD_VERIFY_EN
        state_nx = S_VERIFY1;
`else
        state_nx = S_COLLECT;
`endif
      end
`ifdef IMEM_LOAD_VERIFY_EN
      S_VERIFY1: begin
        mem_addr = word_cnt - AWIDTH'(1);
        state_nx = S_VERIFY2;
      end
      S_VERIFY2: begin
        mem_addr = word_cnt - AWIDTH'(1);
        state_nx = S_COLLECT;
      end
`endif
      // Re-prime the fetch read so the core never sees a stale instruction.
      S_RESUME:  state_nx = S_RUN;
      default:   state_nx = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_RUN;
      ld_ready <= 1'b0;
      ld_wrap  <= 1'b0;
      ld_err   <= 1'b0;
      byte_cnt <= '0;
      word_cnt <= '0;
      pack_q   <= '0;
    end else begin
      state    <= state_nx;
      ld_ready <= (state_nx == S_COLLECT);
      case (state)
        S_RUN: begin
          if (ld_req) begin
            word_cnt <= ld_base;
            byte_cnt <= '0;
            ld_wrap  <= 1'b0;
            ld_err   <= 1'b0;
          end
        end
        S_COLLECT: begin
          if (!ld_req) begin
            if (byte_cnt != '0 || xfer) ld_err <= 1'b1;
            byte_cnt <= '0;
          end else if (xfer) begin
            pack_q   <= {ld_byte, pack_q[SW-1:8]};
            byte_cnt <= byte_cnt + CW'(1);
          end
        end
        S_WRITE: begin
          word_cnt <= word_cnt + AWIDTH'(1);
          if (word_cnt == '1) ld_wrap <= 1'b1;
          byte_cnt <= '0;
        end
`ifdef IMEM_LOAD_VERIFY_EN
        S_VERIFY2: begin
          if (mem_rdata != pack_q[W-1:0]) ld_err <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
